// File: rtl/fifo_pkg.sv
// Shared defaults and a constant-evaluable log2 helper for the FIFO family.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// The read register is the FIFO's dout, so it alone carries a reset; the
// array itself is never reset so it can map onto block RAM.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: store data at the write address when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered output, holds its value when no read is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count, threshold flags
// and overflow/underflow pulses around a fifo_ram storage block.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int DEPTH               = DEFAULT_DEPTH,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2,
    localparam int ADDR_WIDTH         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclr,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_read_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_rd_accept;
    logic w_wr_accept;
    logic w_full;
    logic w_empty;

    // Flags decode straight from the count register.
    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    // A read needs data; a write needs room, or a slot freed by a same-edge
    // read. sclr suppresses both so the clear leaves dout untouched.
    assign w_rd_accept = rden && !w_empty && !sclr;
    assign w_wr_accept = wren && (!w_full || w_rd_accept) && !sclr;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_re    (w_rd_accept),
        .i_raddr (r_rd_ptr),
        .o_rdata (dout)
    );

    // Pointer, occupancy and status-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_read_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (sclr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_read_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
            r_read_valid <= w_rd_accept;
            r_overflow   <= wren && !w_wr_accept;
            r_underflow  <= rden && !w_rd_accept;
        end
    end

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (int'(r_count) >= ALMOST_FULL_THRESH);
    assign almost_empty = (int'(r_count) <= ALMOST_EMPTY_THRESH);
    assign read_valid   = r_read_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param at DEPTH=4: directed vector table, async-reset
// sequence, then random traffic against a queue-based reference model.
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic          clk;
    logic          reset;
    logic          sclr;
    logic          wren;
    logic          rden;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          read_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    int total;
    int bad;

    fifo_param #(
        .DATA_WIDTH          (DW),
        .DEPTH               (DEPTH),
        .ALMOST_FULL_THRESH  (AFT),
        .ALMOST_EMPTY_THRESH (AET)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclr         (sclr),
        .wren         (wren),
        .rden         (rden),
        .din          (din),
        .dout         (dout),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       w;
        logic       r;
        logic [7:0] d;
        logic [7:0] e_dout;
        logic       e_rv;
        int         e_cnt;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against expected dout/valid/count/pulses; flags
    // are the threshold rules applied to the expected count.
    task automatic chk_all(input string tag, input logic [7:0] e_dout, input logic e_rv,
                           input int e_cnt, input logic e_ovf, input logic e_unf);
        chk({tag, ".dout"}, int'(dout), int'(e_dout));
        chk({tag, ".read_valid"}, int'(read_valid), int'(e_rv));
        chk({tag, ".count"}, int'(count), e_cnt);
        chk({tag, ".full"}, int'(full), int'(e_cnt == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(e_cnt == 0));
        chk({tag, ".almost_full"}, int'(almost_full), int'(e_cnt >= AFT));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(e_cnt <= AET));
        chk({tag, ".overflow"}, int'(overflow), int'(e_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(e_unf));
    endtask

    function automatic vec_t mk(input logic s, input logic w, input logic r, input logic [7:0] d,
                                input logic [7:0] ed, input logic erv, input int ec,
                                input logic eo, input logic eu);
        vec_t v;
        v.s = s; v.w = w; v.r = r; v.d = d;
        v.e_dout = ed; v.e_rv = erv; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_dout;
    logic       m_rv, m_ovf, m_unf;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        sclr  = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        din   = '0;

        // Directed vectors: {sclr,wren,rden,din} -> state after the edge
        // idle after reset
        vecs.push_back(mk(0,0,0,8'h00, 8'h00,0,0,0,0));
        // fill, then overflow
        vecs.push_back(mk(0,1,0,8'h11, 8'h00,0,1,0,0));
        vecs.push_back(mk(0,1,0,8'h22, 8'h00,0,2,0,0));
        vecs.push_back(mk(0,1,0,8'h33, 8'h00,0,3,0,0));
        vecs.push_back(mk(0,1,0,8'h44, 8'h00,0,4,0,0));
        vecs.push_back(mk(0,1,0,8'h55, 8'h00,0,4,1,0));
        // drain, then underflow
        vecs.push_back(mk(0,0,1,8'h00, 8'h11,1,3,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h22,1,2,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h33,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h44,1,0,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h44,0,0,0,1));
        // refill, simultaneous write/read at full, drain across the wrap
        vecs.push_back(mk(0,1,0,8'h11, 8'h44,0,1,0,0));
        vecs.push_back(mk(0,1,0,8'h22, 8'h44,0,2,0,0));
        vecs.push_back(mk(0,1,0,8'h33, 8'h44,0,3,0,0));
        vecs.push_back(mk(0,1,0,8'h44, 8'h44,0,4,0,0));
        vecs.push_back(mk(0,1,1,8'h66, 8'h11,1,4,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h22,1,3,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h33,1,2,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h44,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h66,1,0,0,0));
        // simultaneous write/read while empty: no fall-through
        vecs.push_back(mk(0,1,1,8'h77, 8'h66,0,1,0,1));
        vecs.push_back(mk(0,0,1,8'h00, 8'h77,1,0,0,0));
        // sclr with write at count 3, then with read pending
        vecs.push_back(mk(0,1,0,8'h01, 8'h77,0,1,0,0));
        vecs.push_back(mk(0,1,0,8'h02, 8'h77,0,2,0,0));
        vecs.push_back(mk(0,1,0,8'h03, 8'h77,0,3,0,0));
        vecs.push_back(mk(1,1,0,8'h04, 8'h77,0,0,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h77,0,0,0,1));
        vecs.push_back(mk(0,1,0,8'h05, 8'h77,0,1,0,0));
        vecs.push_back(mk(1,0,1,8'h00, 8'h77,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h09, 8'h77,0,1,0,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h09,1,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            sclr = vecs[i].s;
            wren = vecs[i].w;
            rden = vecs[i].r;
            din  = vecs[i].d;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_rv,
                    vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
            $display("vec %0d: s=%0b w=%0b r=%0b din=%02h -> dout=%02h rv=%0b cnt=%0d ovf=%0b unf=%0b",
                     i, vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].d, dout, read_valid, count,
                     overflow, underflow);
        end

        // Async reset mid-cycle: one read leaves rv/dout non-zero, then a
        // pulse of reset between edges must clear outputs immediately.
        wren = 1'b1; din = 8'hA5; rden = 1'b0;
        @(posedge clk); #1;
        wren = 1'b1; din = 8'h5A;
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b1;
        @(posedge clk); #1;
        rden = 1'b0;
        chk_all("pre_areset", 8'hA5, 1, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("areset", 8'h00, 0, 0, 0, 0);
        $display("async reset: dout=%02h cnt=%0d empty=%0b", dout, count, empty);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Random traffic against the queue model
        m_q.delete();
        m_dout = 8'h00;
        for (int i = 0; i < 600; i++) begin
            sclr = ($urandom_range(0, 31) == 0);
            wren = $urandom_range(0, 1) == 1;
            rden = $urandom_range(0, 1) == 1;
            din  = 8'($urandom);
            if (sclr) begin
                m_q.delete();
                m_rv = 0; m_ovf = 0; m_unf = 0;
            end else begin
                logic rd_ok, wr_ok;
                rd_ok = rden && (m_q.size() > 0);
                wr_ok = wren && ((m_q.size() < DEPTH) || rd_ok);
                if (rd_ok) m_dout = m_q.pop_front();
                if (wr_ok) m_q.push_back(din);
                m_rv  = rd_ok;
                m_ovf = wren && !wr_ok;
                m_unf = rden && !rd_ok;
            end
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", i), m_dout, m_rv, m_q.size(), m_ovf, m_unf);
            $display("rnd %0d: s=%0b w=%0b r=%0b din=%02h -> dout=%02h rv=%0b cnt=%0d",
                     i, sclr, wren, rden, din, dout, read_valid, count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the 8-bit lab FIFO. Data width and depth are parameters. Adds a synchronous clear, an occupancy count, almost-full/almost-empty thresholds and overflow/underflow error pulses. Single clock domain. Used as the standard buffering element between datapath stages in exam and lab designs.

Parameters:
DATA_WIDTH, 8, width of din/dout
DEPTH, 16, number of entries; power of two, >= 2
ALMOST_FULL_THRESH, DEPTH-2, almost_full asserts when count >= this value
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when count <= this value
(local) ADDR_WIDTH, $clog2(DEPTH), pointer width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
sclr  input  1  synchronous clear; highest priority after reset
wren  input  1  write request
rden  input  1  read request
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  registered read data
read_valid  output  1  dout updated by an accepted read on the last edge
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_THRESH
almost_empty  output  1  count <= ALMOST_EMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write dropped
underflow  output  1  one-cycle pulse: read ignored

Behaviour:
- Reset (async, reset=1): wr_ptr=rd_ptr=0, count=0, dout=0, read_valid=0, overflow=0, underflow=0. Derived flags: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- sclr=1 at an edge:
  - Same clearing as reset except dout holds its value.
  - wren/rden are ignored that cycle; no pulses are generated.
- Accepted write: wren=1 and (not full, or rden=1 with a read accepted the same edge). din goes to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Accepted read: rden=1 and not empty.
  - dout <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; read_valid=1 for the following cycle.
  - Latency: one edge; dout and read_valid are valid immediately after the accepting edge.
  - When no read is accepted: read_valid=0 and dout holds.
- Simultaneous wren & rden:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read returns the oldest entry, write goes into the freed slot; count stays DEPTH; no overflow.
  - Empty: write accepted, read ignored (no fall-through); read_valid=0; underflow pulses; count becomes 1.
- wren while full with no rden: write dropped; memory and pointers unchanged; overflow=1 for one cycle.
- rden while empty with no wren: nothing changes; underflow=1 for one cycle.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. Registered. All flags decode combinationally from the count register, so they are glitch-free relative to clk.
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap naturally. Ordering is preserved across wrap.

Decomposition:
- Package fifo_pkg: default DATA_WIDTH/DEPTH constants and a clog2 helper function if the toolchain requires one.
- Sub-module fifo_ram: simple dual-port array with synchronous write, synchronous registered read and a read-enable input.
- fifo_param contains the pointers, count, flags and error-pulse logic, and instantiates fifo_ram.

Test Plan (DATA_WIDTH=8, DEPTH=4, ALMOST_FULL_THRESH=3, ALMOST_EMPTY_THRESH=1):
1. Reset release, idle -> dout=00, count=0, empty=1, almost_empty=1, full=0, almost_full=0, read_valid=0.
2. Fill and overflow:
   - Write 11,22,33,44 -> count 1,2,3,4; almost_full rises at count=3; full=1 at count=4.
   - 5th write 55 -> overflow=1 for one cycle; count stays 4.
3. Drain and underflow:
   - From stage 2, four reads -> dout 11,22,33,44 with read_valid=1 each cycle; empty=1 after the 4th.
   - 5th read -> underflow=1, read_valid=0, dout holds 44.
4. Full with simultaneous write 66 and read -> dout=11, count stays 4, no overflow. Then drain -> 22,33,44,66 (pointer wrap verified).
5. Empty with simultaneous wren=1 (din=77) and rden=1 -> read_valid=0, underflow=1, count=1. Next read -> dout=77.
6. Clears mid-operation:
   - With count=3, sclr=1 plus wren=1 at the same edge -> count=0, empty=1, no overflow; dout holds last value.
   - Async reset asserted mid-cycle -> all outputs reach their reset values before the next edge.
